// File: rtl/register_tree_pq.sv
// Register-tree priority queue: per-node valid bits, min/max ordering, replace-top and ready/valid handshakes.
// Define RTPQ_PAYLOAD_EN to store, swap and present a payload alongside each key.

module register_tree_pq #(
    parameter int QUEUE_SIZE    = 7,
    parameter int KEY_WIDTH     = 16,
    parameter int PAYLOAD_WIDTH = 8,
    parameter int MIN_FIRST     = 0
) (
    input  logic                            i_CLK,
    input  logic                            i_RST,
    input  logic                            i_enq,
    input  logic [KEY_WIDTH-1:0]            i_key,
    input  logic [PAYLOAD_WIDTH-1:0]        i_payload,
    output logic                            o_enq_ready,
    input  logic                            i_deq,
    output logic                            o_top_valid,
    output logic [KEY_WIDTH-1:0]            o_top_key,
    output logic [PAYLOAD_WIDTH-1:0]        o_top_payload,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
    output logic                            o_full,
    output logic                            o_empty,
    output logic                            o_drop
);

    localparam int D     = $clog2(QUEUE_SIZE + 1);
    localparam int NODES = (1 << D) - 1;
    localparam int CW    = $clog2(QUEUE_SIZE + 1);
    localparam logic [CW-1:0] CAPACITY    = CW'(QUEUE_SIZE);
    localparam logic [CW-1:0] SETTLE_INIT = CW'(D - 1);

    typedef logic [KEY_WIDTH-1:0] key_t;

    logic          node_valid [NODES];
    key_t          node_key   [NODES];
    logic          cs_valid   [NODES];
    key_t          cs_key     [NODES];
`ifdef RTPQ_PAYLOAD_EN
    logic [PAYLOAD_WIDTH-1:0] node_pl [NODES];
    logic [PAYLOAD_WIDTH-1:0] cs_pl   [NODES];
`endif

    logic [CW-1:0] count;
    logic [CW-1:0] settle;
    logic          enq_fire;
    logic          deq_fire;
    int            ins_idx;
    logic          ins_found;

    // An invalid entry never wins; a valid one beats invalid, otherwise strict key order.
    function automatic logic better(input logic va, input key_t ka, input logic vb, input key_t kb);
        if (!va) return 1'b0;
        if (!vb) return 1'b1;
        return (MIN_FIRST != 0) ? (ka < kb) : (ka > kb);
    endfunction

    function automatic int node_level(input int idx);
        int lvl;
        lvl = 0;
        for (int b = 1; b < 31; b++) begin
            if (((idx + 1) >> b) != 0) lvl = b;
        end
        return lvl;
    endfunction

    assign o_full      = (count == CAPACITY);
    assign o_empty     = (count == '0);
    assign o_count     = count;
    assign o_top_valid = (count != '0) && (settle == '0);
    assign o_enq_ready = !o_full || (i_deq && o_top_valid);
    assign deq_fire    = i_deq && o_top_valid;
    assign enq_fire    = i_enq && o_enq_ready;
    assign o_top_key   = o_top_valid ? node_key[0] : '0;

`ifdef RTPQ_PAYLOAD_EN
    assign o_top_payload = o_top_valid ? node_pl[0] : '0;
`else
    logic unused_payload;
    assign unused_payload = ^i_payload;
    assign o_top_payload  = '0;
`endif

    always_comb begin
        ins_idx   = 0;
        ins_found = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            if (!ins_found && !node_valid[i]) begin
                ins_idx   = i;
                ins_found = 1'b1;
            end
        end
    end

    // Pass 0 works on even-level parents, pass 1 on odd-level parents using pass 0's result.
    always_comb begin
        int   l;
        int   r;
        int   c;
        logic tv;
        key_t tk;
`ifdef RTPQ_PAYLOAD_EN
        logic [PAYLOAD_WIDTH-1:0] tp;
        tp    = '0;
        cs_pl = node_pl;
`endif
        l        = 0;
        r        = 0;
        c        = 0;
        tv       = 1'b0;
        tk       = '0;
        cs_valid = node_valid;
        cs_key   = node_key;
        for (int pass = 0; pass < 2; pass++) begin
            for (int p = 0; p < NODES / 2; p++) begin
                if ((node_level(p) % 2) == pass) begin
                    l = 2 * p + 1;
                    r = 2 * p + 2;
                    c = better(cs_valid[r], cs_key[r], cs_valid[l], cs_key[l]) ? r : l;
                    if (better(cs_valid[c], cs_key[c], cs_valid[p], cs_key[p])) begin
                        tv          = cs_valid[p];
                        tk          = cs_key[p];
                        cs_valid[p] = cs_valid[c];
                        cs_key[p]   = cs_key[c];
                        cs_valid[c] = tv;
                        cs_key[c]   = tk;
`ifdef RTPQ_PAYLOAD_EN
                        tp          = cs_pl[p];
                        cs_pl[p]    = cs_pl[c];
                        cs_pl[c]    = tp;
`endif
                    end
                end
            end
        end
    end

    // Replace beats enqueue beats dequeue; any idle cycle runs one compare-swap step.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            for (int i = 0; i < NODES; i++) begin
                node_valid[i] <= 1'b0;
                node_key[i]   <= '0;
`ifdef RTPQ_PAYLOAD_EN
                node_pl[i]    <= '0;
`endif
            end
            count  <= '0;
            settle <= '0;
            o_drop <= 1'b0;
        end else begin
            o_drop <= i_enq && !o_enq_ready;
            if (enq_fire && deq_fire) begin
                node_valid[0] <= 1'b1;
                node_key[0]   <= i_key;
`ifdef RTPQ_PAYLOAD_EN
                node_pl[0]    <= i_payload;
`endif
                settle <= SETTLE_INIT;
            end else if (enq_fire) begin
                node_valid[ins_idx] <= 1'b1;
                node_key[ins_idx]   <= i_key;
`ifdef RTPQ_PAYLOAD_EN
                node_pl[ins_idx]    <= i_payload;
`endif
                count  <= count + CW'(1);
                settle <= SETTLE_INIT;
            end else if (deq_fire) begin
                node_valid[0] <= 1'b0;
                node_key[0]   <= '0;
`ifdef RTPQ_PAYLOAD_EN
                node_pl[0]    <= '0;
`endif
                count  <= count - CW'(1);
                settle <= SETTLE_INIT;
            end else begin
                node_valid <= cs_valid;
                node_key   <= cs_key;
`ifdef RTPQ_PAYLOAD_EN
                node_pl    <= cs_pl;
`endif
                if (settle != '0) settle <= settle - CW'(1);
            end
        end
    end

endmodule
